// File: rtl/axis_adc_decimator.sv
// axis_adc_decimator
//   Decimates a two-channel ADC sample stream. The block adds up cfg_ratio
//   consecutive sample pairs for each channel. It applies an arithmetic right
//   shift to each sum, saturates the result to the sample width, and emits one
//   packed {chB, chA} word on an AXI-Stream master with a one-deep output
//   register.
//
//   Optional build macro: AXIS_ADC_DECIMATOR_ROUND_EN
//     When defined, 2^(cfg_shift-1) is added to each sum before the shift
//     (round-half-up). When undefined, the shift truncates toward -inf.
//
//   Parameters
//     AXIS_TDATA_WIDTH  sample / output field width (two's complement)
//     CNTR_WIDTH        decimation ratio and counter width
//     ACC_WIDTH         accumulator width, >= AXIS_TDATA_WIDTH + CNTR_WIDTH
//
//   Ports
//     aclk, areset                   clock, synchronous active-high reset
//     cfg_ratio                      samples per output, 0 disables the block
//     cfg_shift                      right shift applied at frame end
//     s00_axis_tvalid/tdata          channel A input (no tready)
//     s01_axis_tvalid/tdata          channel B input (no tready)
//     m_axis_tvalid/tready/tdata     result stream {chB, chA}
//     sts_overrun                    sticky: an unconsumed result was overwritten

// Per-channel accumulate / shift / saturate datapath.
module axis_adc_decimator_lane #(
    parameter int DW        = 16,
    parameter int ACC_WIDTH = 32
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 clr,
    input  logic                 acc_en,
    input  logic                 frame_end,
    input  logic [4:0]           shift,
    input  logic [DW-1:0]        sample,
    output logic [DW-1:0]        result
);
    localparam logic signed [ACC_WIDTH:0] SAT_MAX = {{(ACC_WIDTH-DW+2){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] SAT_MIN = {{(ACC_WIDTH-DW+2){1'b1}}, {(DW-1){1'b0}}};

    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] smp_ext;
    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [ACC_WIDTH:0]   sum_r;
    logic signed [ACC_WIDTH:0]   shr;

    assign smp_ext = {{(ACC_WIDTH-DW){sample[DW-1]}}, sample};
    assign sum     = acc + smp_ext;

    // One guard bit: the rounding bias can push a near-full-scale sum past
    // the accumulator range.
`ifdef AXIS_ADC_DECIMATOR_ROUND_EN
    logic signed [ACC_WIDTH:0] bias;
    assign bias  = (shift == 5'd0) ? '0 : ((ACC_WIDTH+1)'(1) << (shift - 5'd1));
    assign sum_r = {sum[ACC_WIDTH-1], sum} + bias;
`else
    assign sum_r = {sum[ACC_WIDTH-1], sum};
`endif

    assign shr = sum_r >>> shift;

    always_comb begin
        result = shr[DW-1:0];
        if (shr > SAT_MAX)
            result = SAT_MAX[DW-1:0];
        else if (shr < SAT_MIN)
            result = SAT_MIN[DW-1:0];
    end

    always_ff @(posedge aclk) begin
        if (areset || clr || frame_end)
            acc <= '0;
        else if (acc_en)
            acc <= sum;
    end
endmodule

module axis_adc_decimator #(
    parameter int AXIS_TDATA_WIDTH = 16,
    parameter int CNTR_WIDTH       = 16,
    parameter int ACC_WIDTH        = 32
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [CNTR_WIDTH-1:0]         cfg_ratio,
    input  logic [4:0]                    cfg_shift,
    input  logic                          s00_axis_tvalid,
    input  logic [AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic                          s01_axis_tvalid,
    input  logic [AXIS_TDATA_WIDTH-1:0]   s01_axis_tdata,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tvalid,
    output logic [2*AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                          sts_overrun
);
    localparam int NUM_CH = 2;
    localparam int DW     = AXIS_TDATA_WIDTH;

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                       state, state_nxt;
    logic [CNTR_WIDTH-1:0]        cnt;
    logic [CNTR_WIDTH-1:0]        ratio_reg;
    logic                         accept;
    logic                         clr;
    logic                         acc_en;
    logic                         frame_end;
    logic [NUM_CH-1:0][DW-1:0]    smp_pk;
    logic [NUM_CH-1:0][DW-1:0]    res_pk;

    assign accept = s00_axis_tvalid & s01_axis_tvalid;
    assign smp_pk = {s01_axis_tdata, s00_axis_tdata};

    always_ff @(posedge aclk) begin
        if (areset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        acc_en    = 1'b0;
        frame_end = 1'b0;
        case (state)
            IDLE: begin
                clr = 1'b1;
                if (cfg_ratio != '0)
                    state_nxt = ACCUM;
            end
            ACCUM: begin
                if (accept) begin
                    if (cnt == ratio_reg - CNTR_WIDTH'(1)) begin
                        frame_end = 1'b1;
                        // ratio re-latches here; zero parks the block
                        if (cfg_ratio == '0)
                            state_nxt = IDLE;
                    end else begin
                        acc_en = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ratio_reg only follows cfg_ratio at frame boundaries (and on leaving IDLE)
    always_ff @(posedge aclk) begin
        if (areset) begin
            cnt       <= '0;
            ratio_reg <= '0;
        end else if (state == IDLE) begin
            cnt <= '0;
            if (cfg_ratio != '0)
                ratio_reg <= cfg_ratio;
        end else if (frame_end) begin
            cnt       <= '0;
            ratio_reg <= cfg_ratio;
        end else if (acc_en) begin
            cnt <= cnt + CNTR_WIDTH'(1);
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        axis_adc_decimator_lane #(
            .DW        (DW),
            .ACC_WIDTH (ACC_WIDTH)
        ) u_lane (
            .aclk      (aclk),
            .areset    (areset),
            .clr       (clr),
            .acc_en    (acc_en),
            .frame_end (frame_end),
            .shift     (cfg_shift),
            .sample    (smp_pk[c]),
            .result    (res_pk[c])
        );
    end

    // One-deep output register: the freshest result always wins, and
    // overwriting a stalled beat is flagged as an overrun.
    always_ff @(posedge aclk) begin
        if (areset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            sts_overrun   <= 1'b0;
        end else if (frame_end) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= res_pk;
            if (m_axis_tvalid && !m_axis_tready)
                sts_overrun <= 1'b1;
        end else if (m_axis_tvalid && m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axis_adc_decimator.sv
// Directed testbench for axis_adc_decimator. Inputs are driven and outputs
// are sampled on the falling edge. Expected values are hand-computed; the
// rounding build (AXIS_ADC_DECIMATOR_ROUND_EN) selects the alternate constants.
module tb_axis_adc_decimator;
    logic        aclk = 1'b0;
    logic        areset;
    logic [15:0] cfg_ratio;
    logic [4:0]  cfg_shift;
    logic        s00_axis_tvalid, s01_axis_tvalid;
    logic [15:0] s00_axis_tdata, s01_axis_tdata;
    logic        m_axis_tready;
    logic        m_axis_tvalid;
    logic [31:0] m_axis_tdata;
    logic        sts_overrun;

    int n_vec = 0;
    int n_err = 0;
    int xfer_cnt = 0;
    int x0;

    always #5 aclk = ~aclk;

    axis_adc_decimator dut (
        .aclk            (aclk),
        .areset          (areset),
        .cfg_ratio       (cfg_ratio),
        .cfg_shift       (cfg_shift),
        .s00_axis_tvalid (s00_axis_tvalid),
        .s00_axis_tdata  (s00_axis_tdata),
        .s01_axis_tvalid (s01_axis_tvalid),
        .s01_axis_tdata  (s01_axis_tdata),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tdata    (m_axis_tdata),
        .sts_overrun     (sts_overrun)
    );

    always @(posedge aclk)
        if (m_axis_tvalid && m_axis_tready)
            xfer_cnt <= xfer_cnt + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic va, input logic [15:0] a, input logic vb, input logic [15:0] b);
        @(negedge aclk);
        s00_axis_tvalid = va;
        s00_axis_tdata  = a;
        s01_axis_tvalid = vb;
        s01_axis_tdata  = b;
    endtask

    task automatic smp(input logic [15:0] a, input logic [15:0] b);
        drv(1'b1, a, 1'b1, b);
    endtask

    task automatic idle_cyc();
        drv(1'b0, 16'h0, 1'b0, 16'h0);
    endtask

    initial begin
        areset = 1'b1; cfg_ratio = '0; cfg_shift = '0; m_axis_tready = 1'b0;
        s00_axis_tvalid = 1'b0; s01_axis_tvalid = 1'b0;
        s00_axis_tdata = '0; s01_axis_tdata = '0;
        repeat (3) idle_cyc();
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_ovr", sts_overrun, 0);
        areset = 1'b0;

        // 1: ratio 4, shift 2
        cfg_ratio = 16'd4; cfg_shift = 5'd2; m_axis_tready = 1'b1;
        x0 = xfer_cnt;
        smp(16'd1, 16'hFFFC); smp(16'd2, 16'hFFFC); smp(16'd3, 16'hFFFC); smp(16'd4, 16'hFFFC);
        chk("t1_early", m_axis_tvalid, 0);
        idle_cyc();
        chk("t1_tvalid", m_axis_tvalid, 1);
`ifdef AXIS_ADC_DECIMATOR_ROUND_EN
        chk("t1_tdata", m_axis_tdata, 32'hFFFC0003);
`else
        chk("t1_tdata", m_axis_tdata, 32'hFFFC0002);
`endif
        idle_cyc();
        chk("t1_tvalid_fall", m_axis_tvalid, 0);
        chk("t1_xfers", xfer_cnt - x0, 1);

        // 2: saturation, ratio change mid-frame takes effect at boundary
        cfg_shift = 5'd0;
        x0 = xfer_cnt;
        smp(16'h7FFF, 16'h8000); smp(16'h7FFF, 16'h8000);
        cfg_ratio = 16'd1;
        smp(16'h7FFF, 16'h8000); smp(16'h7FFF, 16'h8000);
        idle_cyc();
        chk("t2_tvalid", m_axis_tvalid, 1);
        chk("t2_tdata", m_axis_tdata, 32'h80007FFF);
        chk("t2_ovr", sts_overrun, 0);
        idle_cyc();
        chk("t2_xfers", xfer_cnt - x0, 1);

        // 3: backpressure and overrun, ratio 1
        m_axis_tready = 1'b0;
        smp(16'd5, 16'd0);
        smp(16'd6, 16'd0);
        cfg_ratio = 16'd2;
        chk("t3_first", m_axis_tdata, 32'h00000005);
        chk("t3_ovr0", sts_overrun, 0);
        idle_cyc();
        chk("t3_tdata", m_axis_tdata, 32'h00000006);
        chk("t3_ovr1", sts_overrun, 1);
        idle_cyc();
        chk("t3_hold_v", m_axis_tvalid, 1);
        chk("t3_hold_d", m_axis_tdata, 32'h00000006);
        m_axis_tready = 1'b1;
        x0 = xfer_cnt;
        idle_cyc();
        chk("t3_tvalid_fall", m_axis_tvalid, 0);
        chk("t3_xfers", xfer_cnt - x0, 1);

        // 4: valid gaps, ratio 2
        drv(1'b1, 16'd10, 1'b1, 16'd0);
        drv(1'b1, 16'd99, 1'b0, 16'd0);
        drv(1'b1, 16'd20, 1'b1, 16'd0);
        chk("t4_early", m_axis_tvalid, 0);
        idle_cyc();
        chk("t4_tvalid", m_axis_tvalid, 1);
        chk("t4_tdata", m_axis_tdata, 32'h0000001E);
        idle_cyc();

        // 5a: ratio 0 latched at frame end disables the block
        cfg_ratio = 16'd0;
        smp(16'd1, 16'd1); smp(16'd1, 16'd1);
        idle_cyc();
        chk("t5_last", m_axis_tdata, 32'h00020002);
        idle_cyc();
        x0 = xfer_cnt;
        repeat (6) smp(16'd7, 16'd7);
        idle_cyc(); idle_cyc();
        chk("t5_dis_xfers", xfer_cnt - x0, 0);
        chk("t5_dis_tvalid", m_axis_tvalid, 0);

        // 5b: reset mid-frame discards partial sums
        cfg_ratio = 16'd3;
        smp(16'd1, 16'd0); smp(16'd1, 16'd0);
        idle_cyc();
        areset = 1'b1;
        idle_cyc();
        chk("t5_rst_tvalid", m_axis_tvalid, 0);
        chk("t5_rst_tdata", m_axis_tdata, 0);
        chk("t5_rst_ovr", sts_overrun, 0);
        areset = 1'b0;
        smp(16'd1, 16'd0); smp(16'd1, 16'd0);
        cfg_ratio = 16'd2;
        smp(16'd1, 16'd0);
        idle_cyc();
        chk("t5_tdata", m_axis_tdata, 32'h00000003);
        idle_cyc();

        // 6: rounding vs truncation, ratio 2 shift 1
        cfg_shift = 5'd1;
        smp(16'd1, 16'hFFFF); smp(16'd2, 16'hFFFE);
        idle_cyc();
`ifdef AXIS_ADC_DECIMATOR_ROUND_EN
        chk("t6_pos", m_axis_tdata, 32'hFFFF0002);
`else
        chk("t6_pos", m_axis_tdata, 32'hFFFE0001);
`endif
        idle_cyc();
        smp(16'hFFFF, 16'd1); smp(16'hFFFE, 16'd2);
        idle_cyc();
`ifdef AXIS_ADC_DECIMATOR_ROUND_EN
        chk("t6_neg", m_axis_tdata, 32'h0002FFFF);
`else
        chk("t6_neg", m_axis_tdata, 32'h0001FFFE);
`endif
        idle_cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
